// File: rtl/gridwalk_pkg.sv
// Shared command encoding, grid limits and the saturating step helper
// for the grid-walk move sequencer.
package gridwalk_pkg;

    localparam logic [1:0] DIR_YP = 2'b00;
    localparam logic [1:0] DIR_YM = 2'b01;
    localparam logic [1:0] DIR_XP = 2'b10;
    localparam logic [1:0] DIR_XM = 2'b11;

    localparam logic [3:0] GRID_MAX = 4'd15;

    // Widen to 5 bits so both overflow past 15 and underflow below 0 are visible.
    function automatic logic [3:0] sat_step(input logic [3:0] pos,
                                            input logic [1:0] mag,
                                            input logic       minus);
        logic [4:0] sum;
        logic [3:0] res;
        sum = 5'd0;
        res = pos;
        if (minus) begin
            sum = {1'b0, pos} - {3'b000, mag};
            res = sum[4] ? 4'd0 : sum[3:0];
        end else begin
            sum = {1'b0, pos} + {3'b000, mag};
            res = (sum > {1'b0, GRID_MAX}) ? GRID_MAX : sum[3:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/gridwalk_cmd_fifo.sv
// Small synchronous command FIFO (DEPTH x 4 bits); status comes from the
// registered occupancy count.
module gridwalk_cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [3:0]               din,
    output logic [3:0]               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gridwalk_ctrl.sv
// Grid-walk move sequencer: rotary/program arbitration into a command FIFO,
// paced execution and saturating {y,x} position on led.
module gridwalk_ctrl
    import gridwalk_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int PACE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rot_event,
    input  logic [3:0] rot_cmd,
    input  logic       prog_valid,
    input  logic [3:0] prog_cmd,
    output logic       prog_ready,
    input  logic       clr_ovf,
    output logic [7:0] led,
    output logic       busy,
    output logic       ovf
);
    localparam int              PW        = (PACE_CYCLES > 1) ? $clog2(PACE_CYCLES) : 1;
    localparam logic [PW-1:0]   PACE_LOAD = PW'(PACE_CYCLES - 1);

    logic                   prev_rot;
    logic                   rot_pulse;
    logic                   push;
    logic                   pop;
    logic [3:0]             push_cmd;
    logic [3:0]             head;
    logic [$clog2(DEPTH):0] count;
    logic                   full;
    logic                   empty;
    logic [PW-1:0]          pace_cnt;
    logic [3:0]             pos_x;
    logic [3:0]             pos_y;

    // The rotary input cannot be back-pressured, so it always takes the push slot.
    assign rot_pulse  = rot_event & ~prev_rot;
    assign prog_ready = ~full & ~rot_pulse;
    assign push       = rot_pulse ? ~full : (prog_valid & prog_ready);
    assign push_cmd   = rot_pulse ? rot_cmd : prog_cmd;
    assign pop        = ~empty & (pace_cnt == '0);

    gridwalk_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (push_cmd),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_rot <= 1'b1;
            ovf      <= 1'b0;
            pace_cnt <= '0;
            pos_x    <= '0;
            pos_y    <= '0;
        end else begin
            prev_rot <= rot_event;
            if (rot_pulse & full) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
            if (pop) begin
                pace_cnt <= PACE_LOAD;
                case (head[1:0])
                    DIR_YP:  pos_y <= sat_step(pos_y, head[3:2], 1'b0);
                    DIR_YM:  pos_y <= sat_step(pos_y, head[3:2], 1'b1);
                    DIR_XP:  pos_x <= sat_step(pos_x, head[3:2], 1'b0);
                    default: pos_x <= sat_step(pos_x, head[3:2], 1'b1);
                endcase
            end else if (pace_cnt != '0) begin
                pace_cnt <= pace_cnt - PW'(1);
            end
        end
    end

    assign led  = {pos_y, pos_x};
    assign busy = (count != '0);

endmodule

// File: tb/tb_gridwalk_ctrl.sv
// Directed bench for gridwalk_ctrl: one instance with PACE_CYCLES=1 and one
// with PACE_CYCLES=8, sharing clock and reset.
module tb_gridwalk_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       rot_event = 1'b0;
    logic [3:0] rot_cmd = 4'h0;
    logic       prog_valid = 1'b0;
    logic [3:0] prog_cmd = 4'h0;
    logic       clr_ovf = 1'b0;
    logic       prog_ready;
    logic [7:0] led;
    logic       busy;
    logic       ovf;

    logic       rot_event_b = 1'b0;
    logic [3:0] rot_cmd_b = 4'h0;
    logic       prog_valid_b = 1'b0;
    logic [3:0] prog_cmd_b = 4'h0;
    logic       clr_ovf_b = 1'b0;
    logic       prog_ready_b;
    logic [7:0] led_b;
    logic       busy_b;
    logic       ovf_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gridwalk_ctrl #(.DEPTH(4), .PACE_CYCLES(1)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .rot_event  (rot_event),
        .rot_cmd    (rot_cmd),
        .prog_valid (prog_valid),
        .prog_cmd   (prog_cmd),
        .prog_ready (prog_ready),
        .clr_ovf    (clr_ovf),
        .led        (led),
        .busy       (busy),
        .ovf        (ovf)
    );

    gridwalk_ctrl #(.DEPTH(4), .PACE_CYCLES(8)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .rot_event  (rot_event_b),
        .rot_cmd    (rot_cmd_b),
        .prog_valid (prog_valid_b),
        .prog_cmd   (prog_cmd_b),
        .prog_ready (prog_ready_b),
        .clr_ovf    (clr_ovf_b),
        .led        (led_b),
        .busy       (busy_b),
        .ovf        (ovf_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic prog_move(input logic [3:0] cmd);
        prog_valid = 1'b1;
        prog_cmd   = cmd;
        step();
        prog_valid = 1'b0;
        step();
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_led",        led,              8'h00);
        check("rst_busy",       8'(busy),         8'h00);
        check("rst_ovf",        8'(ovf),          8'h00);
        check("rst_prog_ready", 8'(prog_ready),   8'h01);
        check("rst_led_b",      led_b,            8'h00);
        rst_n = 1'b1;
        step();

        // Rotary x+3 from reset
        rot_event = 1'b1;
        rot_cmd   = 4'b1110;
        step();
        check("rot_push_busy", 8'(busy), 8'h01);
        check("rot_push_led",  led,      8'h00);
        rot_event = 1'b0;
        step();
        check("rot_exec_led",  led,      8'h03);
        check("rot_exec_busy", 8'(busy), 8'h00);

        // Saturation in both directions
        prog_move(4'b1110);
        prog_move(4'b1110);
        prog_move(4'b1110);
        prog_move(4'b1010);
        check("x_at_14",   led, 8'h0E);
        prog_move(4'b1110);
        check("x_sat_15",  led, 8'h0F);
        prog_move(4'b0100);
        check("y_at_1",    led, 8'h1F);
        prog_move(4'b1101);
        check("y_sat_0",   led, 8'h0F);
        prog_move(4'b0011);
        check("x_mag0",    led, 8'h0F);
        prog_move(4'b1111);
        check("x_minus_3", led, 8'h0C);

        // Rotary and program in the same cycle
        #2 rst_n = 1'b0;
        step();
        check("rst2_led", led, 8'h00);
        rst_n = 1'b1;
        step();
        rot_event  = 1'b1;
        rot_cmd    = 4'b0110;
        prog_valid = 1'b1;
        prog_cmd   = 4'b0100;
        #1;
        check("arb_ready_low", 8'(prog_ready), 8'h00);
        step();
        rot_event = 1'b0;
        #1;
        check("arb_ready_high", 8'(prog_ready), 8'h01);
        check("arb_led0",       led,            8'h00);
        step();
        prog_valid = 1'b0;
        check("arb_rot_first", led, 8'h01);
        step();
        check("arb_final",      led,      8'h11);
        check("arb_idle",       8'(busy), 8'h00);

        // Paced instance: primer move starts the pace counter, then 5 rotary rises
        prog_valid_b = 1'b1;
        prog_cmd_b   = 4'b0010;
        step();
        prog_valid_b = 1'b0;
        rot_cmd_b    = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            rot_event_b = 1'b1;
            step();
            rot_event_b = 1'b0;
            step();
        end
        check("pace_full_ovf0",  8'(ovf_b),        8'h00);
        check("pace_full_ready", 8'(prog_ready_b), 8'h00);
        check("pace_full_led",   led_b,            8'h00);
        rot_event_b = 1'b1;
        step();
        rot_event_b = 1'b0;
        check("pace_drop_ovf",   8'(ovf_b),  8'h01);
        check("pace_first_led",  led_b,      8'h01);
        check("pace_busy",       8'(busy_b), 8'h01);
        repeat (30) step();
        check("pace_final_led",  led_b,      8'h04);
        check("pace_final_busy", 8'(busy_b), 8'h00);
        check("pace_ovf_sticky", 8'(ovf_b),  8'h01);
        clr_ovf_b = 1'b1;
        step();
        clr_ovf_b = 1'b0;
        check("pace_ovf_clr",    8'(ovf_b),  8'h00);

        // Reset mid-pace discards queued entries
        prog_valid_b = 1'b1;
        prog_cmd_b   = 4'b0110;
        repeat (4) step();
        prog_valid_b = 1'b0;
        check("mid_queue_led",  led_b,      8'h05);
        check("mid_queue_busy", 8'(busy_b), 8'h01);
        step();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_led",  led_b,      8'h00);
        check("mid_rst_busy", 8'(busy_b), 8'h00);
        step();
        rst_n = 1'b1;
        repeat (30) step();
        check("post_rst_led",   led_b,            8'h00);
        check("post_rst_busy",  8'(busy_b),       8'h00);
        check("post_rst_ready", 8'(prog_ready_b), 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
